// File: rtl/decode_trace_buffer.sv
// Run-length compressing trace FIFO for LC3 decode-stage outputs.
// Optional opcode filter: define DECODE_TRACE_OPCODE_FILTER_EN to add filter_en/filter_opcode.
module decode_trace_buffer #(
    parameter int IR_W  = 16,
    parameter int NPC_W = 16,
    parameter int DEPTH = 16,
    parameter int TS_W  = 16,
    parameter int RUN_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable_decode,
    input  logic [IR_W-1:0]          ir,
    input  logic [NPC_W-1:0]         npc_out,
    input  logic [5:0]               E_control,
    input  logic [1:0]               W_control,
    input  logic                     mem_control,
`ifdef DECODE_TRACE_OPCODE_FILTER_EN
    input  logic                     filter_en,
    input  logic [3:0]               filter_opcode,
`endif
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [IR_W-1:0]          rd_ir,
    output logic [NPC_W-1:0]         rd_npc,
    output logic [5:0]               rd_E_control,
    output logic [1:0]               rd_W_control,
    output logic                     rd_mem_control,
    output logic [TS_W-1:0]          rd_start_ts,
    output logic [RUN_W-1:0]         rd_run_len,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_count
);

    localparam int TUP_W = IR_W + NPC_W + 9;
    localparam int ENT_W = TUP_W + TS_W + RUN_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {S_IDLE, S_ACCUM} state_t;

    state_t               r_state;
    logic [TUP_W-1:0]     r_tuple;
    logic [TS_W-1:0]      r_start_ts;
    logic [RUN_W-1:0]     r_run;
    logic [TS_W-1:0]      r_ts;

    logic [ENT_W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [ENT_W-1:0]     r_head;
    logic                 r_overflow;
    logic [15:0]          r_drop_count;

    logic [TUP_W-1:0]     w_tuple;
    logic                 w_en;
    logic                 w_run_sat;
    logic                 w_close;
    logic [ENT_W-1:0]     w_entry;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_wr;
    logic                 w_drop;
    logic [PTR_W-1:0]     w_rd_ptr_nxt;
    logic                 w_head_load;
    logic [ENT_W-1:0]     w_head_nxt;

    assign w_tuple = {ir, npc_out, E_control, W_control, mem_control};

`ifdef DECODE_TRACE_OPCODE_FILTER_EN
    assign w_en = enable_decode && (!filter_en || (ir[IR_W-1 -: 4] == filter_opcode));
`else
    assign w_en = enable_decode;
`endif

    assign w_run_sat    = (r_run == {RUN_W{1'b1}});
    assign w_close      = (r_state == S_ACCUM) && (!w_en || (w_tuple != r_tuple) || w_run_sat);
    assign w_entry      = {r_tuple, r_start_ts, r_run};
    assign w_pop        = (r_count != '0) && rd_ready;
    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_wr         = w_close && (!w_full || w_pop);
    assign w_drop       = w_close && w_full && !w_pop;
    assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);

    // Output register tracks the head as it will be after this edge; holds when empty.
    always_comb begin
        w_head_load = 1'b0;
        w_head_nxt  = r_head;
        if (w_pop) begin
            if (r_count > CNT_W'(1)) begin
                w_head_load = 1'b1;
                w_head_nxt  = r_mem[w_rd_ptr_nxt];
            end else if (w_wr) begin
                w_head_load = 1'b1;
                w_head_nxt  = w_entry;
            end
        end else if ((r_count == '0) && w_wr) begin
            w_head_load = 1'b1;
            w_head_nxt  = w_entry;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_tuple    <= '0;
            r_start_ts <= '0;
            r_run      <= '0;
            r_ts       <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
            case (r_state)
                S_IDLE: begin
                    if (w_en) begin
                        r_tuple    <= w_tuple;
                        r_start_ts <= r_ts;
                        r_run      <= RUN_W'(1);
                        r_state    <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (!w_en) begin
                        r_state <= S_IDLE;
                    end else if (w_close) begin
                        r_tuple    <= w_tuple;
                        r_start_ts <= r_ts;
                        r_run      <= RUN_W'(1);
                    end else begin
                        r_run <= r_run + RUN_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_head       <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_head_load) begin
                r_head <= w_head_nxt;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 16'hFFFF) begin
                    r_drop_count <= r_drop_count + 16'd1;
                end
            end
        end
    end

    assign rd_valid       = (r_count != '0);
    assign count          = r_count;
    assign overflow       = r_overflow;
    assign drop_count     = r_drop_count;
    assign {rd_ir, rd_npc, rd_E_control, rd_W_control, rd_mem_control, rd_start_ts, rd_run_len} = r_head;

endmodule

// File: doc/decode_trace_buffer.md
Name: decode_trace_buffer

Overview:
Synthesizable, parametrised capture buffer for LC3 decode-stage outputs (ir, npc_out, E_control, W_control, mem_control). Samples the decode outputs each enabled cycle and run-length compresses identical consecutive samples (stalls) into one entry. Each entry carries a start timestamp and run length. Entries are queued in a FIFO and drained by a valid/ready reader such as a debug port or bench scoreboard. Sits beside the decode stage, observing only.

Parameters:
IR_W, 16, instruction register width
NPC_W, 16, next-PC width
DEPTH, 16, FIFO entries; power of 2, >=2
TS_W, 16, free-running timestamp width
RUN_W, 8, run-length counter width

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous active-low reset
enable_decode  in  1  decode outputs valid this cycle
ir  in  IR_W  decode ir
npc_out  in  NPC_W  decode npc_out
E_control  in  6  execute control
W_control  in  2  writeback control
mem_control  in  1  memory control
rd_ready  in  1  reader accepts head entry
rd_valid  out  1  head entry valid
rd_ir  out  IR_W  head ir
rd_npc  out  NPC_W  head npc_out
rd_E_control  out  6  head E_control
rd_W_control  out  2  head W_control
rd_mem_control  out  1  head mem_control
rd_start_ts  out  TS_W  timestamp of the entry's first sample
rd_run_len  out  RUN_W  consecutive identical samples (>=1)
count  out  $clog2(DEPTH)+1  FIFO occupancy
overflow  out  1  sticky; an entry was dropped
drop_count  out  16  saturating count of dropped entries

Behaviour:
- Reset (reset=0, async): all outputs 0; FIFO empty; timestamp 0; pending state IDLE.
- Timestamp: increments every clock; wraps at 2^TS_W-1 -> 0.
- Sample tuple: {ir, npc_out, E_control, W_control, mem_control}.
- Pending FSM:
  - IDLE: enable_decode=1 -> load pending tuple, start_ts=current ts, run=1; go to ACCUM.
  - ACCUM, enable_decode=1, tuple equal, run<2^RUN_W-1 -> run++.
  - ACCUM, enable_decode=1, tuple differs or run saturated -> close pending: push it, then load the new sample (start_ts=ts, run=1); stay in ACCUM.
  - ACCUM, enable_decode=0 -> close pending; go to IDLE.
- Push: written on the same edge that closes the pending entry. rd_valid and count reflect the entry after that edge. Capture-to-output latency is 1 cycle after the close cycle.
- Pop: rd_valid&&rd_ready at an edge removes the head. rd_* always shows the head entry, and holds it stably while rd_valid=1 and rd_ready=0.
- Full: a push when count==DEPTH with no pop that cycle drops the entry. On a drop: overflow<=1 (sticky until reset); drop_count++ saturating at 16'hFFFF. A push with a simultaneous pop when full is accepted, and count is unchanged.
- Simultaneous push+pop when not full: count unchanged.
- Empty: rd_valid=0; rd_* hold their last value.
- Pointers wrap modulo DEPTH.
- Reset mid-run: the pending entry and all FIFO contents are discarded.

Optional Feature:
DECODE_TRACE_OPCODE_FILTER_EN
- Defined: adds input ports filter_en (1) and filter_opcode (4). When filter_en=1, a sample is treated as enable_decode=0 unless ir[IR_W-1:IR_W-4]==filter_opcode, so the pending entry closes on a non-matching sample.
- Undefined: the ports are absent and every enabled sample is captured.

Test Plan:
- Reset, then 3 enabled cycles with ir=16'h1234, 16'h5678, 16'h9ABC, then enable low; rd_ready=1 -> 3 entries in order, each with run_len=1 and start_ts 1 apart.
- Stall: ir=16'h2002 held for 5 enabled cycles, then enable low -> exactly one entry, run_len=5; rd_start_ts equals the ts at the first sample.
- RUN_W=3, identical tuple for 10 enabled cycles -> entries with run_len=7, then run_len=3.
- DEPTH=4, rd_ready=0, 6 distinct samples -> count=4; overflow=1 and drop_count=1 after the 6th sample closes (the 5th entry is dropped); the first 4 entries drain intact.
- Full FIFO with rd_ready=1 in the same cycle as a push -> count stays 4, no drop, and the new entry appears last.
- Assert reset for 1 cycle mid-accumulation (run=3) -> rd_valid=0, count=0, overflow=0; the next sample starts a new entry with run_len=1.
